// File: rtl/ofm_writeback_packer_if.sv
// ofm_writeback_packer_if: PE capture port and OFM BRAM write port of the
// OFM writeback packer. The master modport is the packer's view.
interface ofm_writeback_packer_if #(
  parameter int NUM_PE = 16,
  parameter int DATA_W = 8,
  parameter int WORD_W = 32,
  parameter int ADDR_W = 20
);
  logic [NUM_PE-1:0]        pe_valid;
  logic [NUM_PE*DATA_W-1:0] pe_data;
  logic                     pe_ready;
  logic                     wr_en;
  logic [ADDR_W-1:0]        wr_addr;
  logic [WORD_W-1:0]        wr_data;
  logic                     wr_ready;

  modport master (
    input  pe_valid, pe_data, wr_ready,
    output pe_ready, wr_en, wr_addr, wr_data
  );

  modport slave (
    output pe_valid, pe_data, wr_ready,
    input  pe_ready, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/ofm_writeback_packer.sv
// ofm_writeback_packer: captures one 16-lane OFM pixel per push into a small
// FIFO and writes it as four big-endian 32-bit words into the OFM BRAM in HWC
// layout. Arrival is group-major; address = p*(C/4) + g*4 + k, built from
// counters only.
// Optional feature macro: OFM_WB_CHECKSUM_EN adds a checksum port holding the
// mod-2^32 sum of every accepted write word since the last cfg_start.
module ofm_writeback_packer #(
  parameter int NUM_PE     = 16,
  parameter int DATA_W     = 8,
  parameter int WORD_W     = 32,
  parameter int ADDR_W     = 20,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cfg_start,
  input  logic [7:0]             OFM_W,
  input  logic [7:0]             OFM_C,
  ofm_writeback_packer_if.master bus,
  output logic                   busy,
  output logic                   done,
  output logic                   cfg_err,
  output logic                   ovf_err
`ifdef OFM_WB_CHECKSUM_EN
  ,
  output logic [WORD_W-1:0]      checksum
`endif
);

  localparam int ENTRY_W        = NUM_PE * DATA_W;
  localparam int LANES_PER_WORD = WORD_W / DATA_W;
  localparam int BEATS          = NUM_PE / LANES_PER_WORD;
  localparam int BEAT_W         = $clog2(BEATS);
  localparam int PTR_W          = $clog2(FIFO_DEPTH);
  localparam int CNT_W          = PTR_W + 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
  localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t              state_r, state_s;
  logic [ENTRY_W-1:0]  fifo_mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_r, rd_ptr_r;
  logic [CNT_W-1:0]    count_r, count_s;
  logic                pe_ready_r, wr_en_r, busy_r, done_r, cfg_err_r, ovf_err_r;
  logic [15:0]         pix_last_r, pix_r;
  logic [3:0]          grp_last_r, grp_r;
  logic [ADDR_W-1:0]   row_step_r, grp_base_r, row_base_r;
  logic [BEAT_W-1:0]   beat_r;
  logic [ENTRY_W-1:0]  head_s;
  logic [WORD_W-1:0]   wr_data_s;
  logic                all_valid_s, cfg_ok_s, idle_cfg_s, start_s, push_s;
  logic                beat_fire_s, pop_s, last_fire_s;

  assign all_valid_s = &bus.pe_valid;
  assign cfg_ok_s    = (OFM_C[3:0] == 4'd0) && (OFM_C != 8'd0) && (OFM_W != 8'd0);
  assign idle_cfg_s  = cfg_start && (state_r == ST_IDLE);
  assign start_s     = idle_cfg_s && cfg_ok_s;
  assign push_s      = (state_r == ST_RUN) && all_valid_s && pe_ready_r;
  assign beat_fire_s = wr_en_r && bus.wr_ready;
  assign pop_s       = beat_fire_s && (beat_r == LAST_BEAT);
  assign last_fire_s = pop_s && (state_r == ST_RUN) &&
                       (pix_r == pix_last_r) && (grp_r == grp_last_r);

  // Next-state logic: IDLE -> RUN on a good config, RUN -> DONE on the final beat.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: if (start_s) state_s = ST_RUN; else state_s = ST_IDLE;
      ST_RUN:  if (last_fire_s) state_s = ST_DONE; else state_s = ST_RUN;
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // Next FIFO occupancy; a new run or the final beat flushes the FIFO.
  always_comb begin
    count_s = count_r;
    if (start_s || last_fire_s) begin
      count_s = '0;
    end else if (push_s && !pop_s) begin
      count_s = count_r + CNT_W'(1);
    end else if (!push_s && pop_s) begin
      count_s = count_r - CNT_W'(1);
    end else begin
      count_s = count_r;
    end
  end

  // Select beat k of the head entry, lane 4k in the most significant byte.
  always_comb begin
    wr_data_s = '0;
    head_s    = fifo_mem_r[rd_ptr_r];
    if (wr_en_r) begin
      for (int j = 0; j < LANES_PER_WORD; j++) begin
        wr_data_s[WORD_W-1-j*DATA_W -: DATA_W] =
          head_s[(int'(beat_r)*LANES_PER_WORD + j)*DATA_W +: DATA_W];
      end
    end else begin
      wr_data_s = '0;
    end
  end

  // FSM state, FIFO pointers/occupancy and registered status outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= ST_IDLE;
      count_r    <= '0;
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      pe_ready_r <= 1'b1;
      wr_en_r    <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      cfg_err_r  <= 1'b0;
      ovf_err_r  <= 1'b0;
    end else begin
      state_r    <= state_s;
      count_r    <= count_s;
      pe_ready_r <= (count_s != FULL_CNT);
      wr_en_r    <= (count_s != '0);
      busy_r     <= (state_s != ST_IDLE);
      done_r     <= (state_s == ST_DONE);
      if (start_s || last_fire_s) begin
        wr_ptr_r <= '0;
        rd_ptr_r <= '0;
      end else begin
        if (push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
        if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      if (idle_cfg_s && !cfg_ok_s) cfg_err_r <= 1'b1;
      // pe_ready is the registered view, so a full-cycle push is lost even if the head pops.
      if (all_valid_s && !pe_ready_r) ovf_err_r <= 1'b1;
    end
  end

  // Pixel storage; written only on an accepted capture.
  always_ff @(posedge clk) begin
    if (push_s) fifo_mem_r[wr_ptr_r] <= bus.pe_data;
  end

  // Config latch and address counters: row base steps by C/4 per pixel and
  // restarts at g*4 when the pixel counter wraps into the next group.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pix_last_r <= 16'd0;
      grp_last_r <= 4'd0;
      row_step_r <= '0;
      pix_r      <= 16'd0;
      grp_r      <= 4'd0;
      grp_base_r <= '0;
      row_base_r <= '0;
      beat_r     <= '0;
    end else if (start_s) begin
      pix_last_r <= 16'(OFM_W) * 16'(OFM_W) - 16'd1;
      grp_last_r <= OFM_C[7:4] - 4'd1;
      row_step_r <= ADDR_W'(OFM_C[7:2]);
      pix_r      <= 16'd0;
      grp_r      <= 4'd0;
      grp_base_r <= '0;
      row_base_r <= '0;
      beat_r     <= '0;
    end else if (beat_fire_s) begin
      if (beat_r == LAST_BEAT) begin
        beat_r <= '0;
        if (pix_r == pix_last_r) begin
          pix_r      <= 16'd0;
          grp_r      <= grp_r + 4'd1;
          grp_base_r <= grp_base_r + ADDR_W'(4);
          row_base_r <= grp_base_r + ADDR_W'(4);
        end else begin
          pix_r      <= pix_r + 16'd1;
          row_base_r <= row_base_r + row_step_r;
        end
      end else begin
        beat_r <= beat_r + BEAT_W'(1);
      end
    end
  end

`ifdef OFM_WB_CHECKSUM_EN
  logic [WORD_W-1:0] checksum_r;

  // Running sum of accepted write words, cleared by reset and by cfg_start.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      checksum_r <= '0;
    end else if (idle_cfg_s) begin
      checksum_r <= '0;
    end else if (beat_fire_s) begin
      checksum_r <= checksum_r + wr_data_s;
    end
  end

  assign checksum = checksum_r;
`endif

  // Row base and group base are multiples of 4, so the beat index fills the low bits.
  assign bus.wr_addr  = row_base_r | ADDR_W'(beat_r);
  assign bus.wr_data  = wr_data_s;
  assign bus.wr_en    = wr_en_r;
  assign bus.pe_ready = pe_ready_r;
  assign busy         = busy_r;
  assign done         = done_r;
  assign cfg_err      = cfg_err_r;
  assign ovf_err      = ovf_err_r;

endmodule

// File: tb/tb_ofm_writeback_packer.sv
// tb_ofm_writeback_packer: randomized scoreboard bench for ofm_writeback_packer.
// Expected BRAM beats are computed from pixel order, OFM_W and OFM_C with
// plain arithmetic and queued; a monitor pops and compares accepted beats.
module tb_ofm_writeback_packer;
  localparam int NUM_PE = 16;
  localparam int DATA_W = 8;
  localparam int WORD_W = 32;
  localparam int ADDR_W = 20;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [WORD_W-1:0] data;
  } beat_t;

  logic clk;
  logic reset;
  logic cfg_start;
  logic [7:0] ofm_w, ofm_c;
  logic busy, done, cfg_err, ovf_err;
`ifdef OFM_WB_CHECKSUM_EN
  logic [31:0] checksum;
`endif

  ofm_writeback_packer_if #(.NUM_PE(NUM_PE), .DATA_W(DATA_W), .WORD_W(WORD_W), .ADDR_W(ADDR_W)) bus ();

  ofm_writeback_packer #(.NUM_PE(NUM_PE), .DATA_W(DATA_W), .WORD_W(WORD_W), .ADDR_W(ADDR_W), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .cfg_start(cfg_start), .OFM_W(ofm_w), .OFM_C(ofm_c),
    .bus(bus), .busy(busy), .done(done), .cfg_err(cfg_err), .ovf_err(ovf_err)
`ifdef OFM_WB_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  int rdy_mode = 0;
  int mw = 1, mc = 16, pix_idx = 0;
  logic [31:0] exp_sum = 32'd0;
  beat_t exp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected beats of the next pixel in arrival order (group-major, raster inside a group).
  task automatic model_pixel(input logic [NUM_PE*DATA_W-1:0] px);
    int pp, g, p;
    beat_t b;
    pp = mw * mw;
    g  = pix_idx / pp;
    p  = pix_idx % pp;
    for (int k = 0; k < 4; k++) begin
      b.addr = ADDR_W'(p * (mc / 4) + g * 4 + k);
      b.data = {px[(4*k)*8 +: 8], px[(4*k+1)*8 +: 8], px[(4*k+2)*8 +: 8], px[(4*k+3)*8 +: 8]};
      exp_q.push_back(b);
      exp_sum = exp_sum + b.data;
    end
    pix_idx++;
  endtask

  task automatic do_cfg(input int w, input int c, input bit model);
    ofm_w = 8'(w);
    ofm_c = 8'(c);
    cfg_start = 1'b1;
    if (model) begin
      mw = w; mc = c; pix_idx = 0; exp_sum = 32'd0;
    end
    tick();
    cfg_start = 1'b0;
    if (model) check("busy_after_cfg", {63'd0, busy}, 64'd1);
  endtask

  function automatic logic [NUM_PE*DATA_W-1:0] rand_px();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Producer that honours pe_ready; random gaps carry partial (ignored) pe_valid.
  task automatic push_wait(input logic [NUM_PE*DATA_W-1:0] px, input int max_gap);
    int t = 0;
    logic [NUM_PE-1:0] pv;
    repeat ($urandom_range(0, max_gap)) begin
      pv = NUM_PE'($urandom);
      pv[$urandom_range(0, NUM_PE-1)] = 1'b0;
      bus.pe_valid = pv;
      bus.pe_data  = rand_px();
      tick();
    end
    bus.pe_valid = '0;
    while (bus.pe_ready !== 1'b1 && t < 300) begin
      tick();
      t++;
    end
    if (t >= 300) begin
      check("pe_ready_timeout", 64'd0, 64'd1);
    end else begin
      bus.pe_valid = '1;
      bus.pe_data  = px;
      model_pixel(px);
      tick();
      bus.pe_valid = '0;
    end
  endtask

  task automatic push_raw(input logic [NUM_PE*DATA_W-1:0] px, input bit accepted);
    bus.pe_valid = '1;
    bus.pe_data  = px;
    if (accepted) model_pixel(px);
    tick();
    bus.pe_valid = '0;
  endtask

  task automatic wait_done();
    int t = 0;
    int d0 = done_cnt;
    while (done_cnt == d0 && t < 4000) begin
      tick();
      t++;
    end
    check("done_seen", {63'd0, done_cnt != d0}, 64'd1);
    check("done_fall_busy_fall", {62'd0, done, busy}, 64'd0);
`ifdef OFM_WB_CHECKSUM_EN
    check("checksum_hold", {32'd0, checksum}, {32'd0, exp_sum});
`endif
    repeat (3) tick();
    check("done_once", 64'(done_cnt - d0), 64'd1);
  endtask

  task automatic check_reset_outputs();
    check("rst_flags", {58'd0, bus.pe_ready, bus.wr_en, busy, done, cfg_err, ovf_err}, 64'h20);
    check("rst_addr_data", {12'd0, bus.wr_addr, bus.wr_data}, 64'd0);
`ifdef OFM_WB_CHECKSUM_EN
    check("rst_checksum", {32'd0, checksum}, 64'd0);
`endif
  endtask

  task automatic reset_pulse();
    tick();
    reset = 1'b0;
    exp_q.delete();
    tick();
    check_reset_outputs();
    reset = 1'b1;
    tick();
  endtask

  task automatic run_t1();
    logic [NUM_PE*DATA_W-1:0] px;
    do_cfg(2, 16, 1'b1);
    for (int p = 0; p < 4; p++) begin
      for (int k = 0; k < 16; k++) px[k*8 +: 8] = 8'(k + 16*p);
      push_wait(px, 3);
    end
    wait_done();
  endtask

  // wr_ready driver: always ready, random backpressure, or stalled.
  initial begin
    bus.wr_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       bus.wr_ready = 1'b1;
        1:       bus.wr_ready = ($urandom_range(0, 9) < 6);
        2:       bus.wr_ready = 1'b0;
        default: bus.wr_ready = 1'b1;
      endcase
    end
  end

  // Monitor: score accepted beats, check hold during stalls, count done pulses.
  initial begin
    beat_t e;
    bit hold_pending;
    logic [ADDR_W-1:0] hold_addr;
    logic [WORD_W-1:0] hold_data;
    hold_pending = 1'b0;
    forever begin
      @(negedge clk);
      if (reset !== 1'b1) begin
        hold_pending = 1'b0;
      end else begin
        if (hold_pending)
          check("hold_stable", {11'd0, bus.wr_en, bus.wr_addr, bus.wr_data}, {11'd0, 1'b1, hold_addr, hold_data});
        if (bus.wr_en === 1'b1) begin
          if (bus.wr_ready === 1'b1) begin
            hold_pending = 1'b0;
            if (exp_q.size() == 0) begin
              check("unexpected_beat", {12'd0, bus.wr_addr, bus.wr_data}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
              e = exp_q.pop_front();
              check("beat", {12'd0, bus.wr_addr, bus.wr_data}, {12'd0, e.addr, e.data});
            end
          end else begin
            hold_pending = 1'b1;
            hold_addr = bus.wr_addr;
            hold_data = bus.wr_data;
          end
        end else begin
          hold_pending = 1'b0;
        end
        if (done === 1'b1) begin
          done_cnt++;
          check("done_busy_queue", {31'd0, busy, 32'(exp_q.size())}, {31'd0, 1'b1, 32'd0});
`ifdef OFM_WB_CHECKSUM_EN
          check("checksum_at_done", {32'd0, checksum}, {32'd0, exp_sum});
`endif
        end
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, c, d0;
    reset = 1'b0;
    cfg_start = 1'b0;
    ofm_w = 8'd0;
    ofm_c = 8'd0;
    bus.pe_valid = '0;
    bus.pe_data = '0;
    repeat (3) tick();
    check_reset_outputs();
    reset = 1'b1;
    tick();

    // T1: 2x2x16, lanes k + 16p, always ready.
    rdy_mode = 0;
    run_t1();

    // T2: 2x2x32 with an ignored cfg_start mid-run.
    do_cfg(2, 32, 1'b1);
    for (int i = 0; i < 8; i++) begin
      push_wait(rand_px(), 2);
      if (i == 2) do_cfg(4, 16, 1'b0);
    end
    wait_done();

    // Random shapes under random backpressure.
    rdy_mode = 1;
    for (int r = 0; r < 6; r++) begin
      w = $urandom_range(1, 4);
      c = 16 * $urandom_range(1, 3);
      do_cfg(w, c, 1'b1);
      for (int i = 0; i < w * w * c / 16; i++) push_wait(rand_px(), 4);
      wait_done();
    end
    check("no_errors_so_far", {62'd0, cfg_err, ovf_err}, 64'd0);

    // T3: stalled BRAM, 5 pushes every 4 cycles: 4 buffered, 5th overflows.
    rdy_mode = 2;
    repeat (2) tick();
    do_cfg(2, 16, 1'b1);
    for (int i = 0; i < 5; i++) begin
      push_raw(rand_px(), i < 4);
      if (i == 3) check("t3_full_no_ovf", {62'd0, bus.pe_ready, ovf_err}, 64'd0);
      if (i == 4) check("t3_ovf", {62'd0, bus.pe_ready, ovf_err}, 64'd1);
      repeat (3) tick();
    end
    rdy_mode = 0;
    wait_done();
    check("t3_ovf_sticky", {63'd0, ovf_err}, 64'd1);

    // T4: bad channel count, then zero width after a reset.
    do_cfg(2, 24, 1'b0);
    check("t4_cfg_err_c24", {62'd0, cfg_err, busy}, 64'd2);
    push_raw(rand_px(), 1'b0);
    repeat (10) tick();
    check("t4_no_wr", {63'd0, bus.wr_en}, 64'd0);
    reset_pulse();
    do_cfg(0, 16, 1'b0);
    check("t4_cfg_err_w0", {62'd0, cfg_err, busy}, 64'd2);

    // T5: reset after 2 of 4 pixels aborts the run with no done pulse.
    reset_pulse();
    check("t5_flags_clear", {62'd0, cfg_err, ovf_err}, 64'd0);
    do_cfg(2, 16, 1'b1);
    push_wait(rand_px(), 0);
    push_wait(rand_px(), 0);
    d0 = done_cnt;
    reset_pulse();
    repeat (20) tick();
    check("t5_no_done", 64'(done_cnt - d0), 64'd0);
    run_t1();

    repeat (3) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
